player_motion_fsm: RTL and testbench

Per-frame horizontal motion controller for the player sprite, generalising the fixed-step player mover. It adds parametrised bounds, fixed-point acceleration and friction, sticky collision capture, and a timed knockback state. It sits between the key decoder / collision detector and the player bitmap/drawing block, and updates position once per `startOfFrame`.

---
 rtl/player_pkg.sv | 17 +
 rtl/speed_step.sv | 35 +++
 rtl/player_motion_fsm.sv | 191 +++++++++++++++++++
 tb/tb_player_motion_fsm.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/player_pkg.sv
// Shared types and constants for the player motion controller.
package player_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MOVE  = 2'd1,
    KNOCK = 2'd2
  } motion_state_t;

  localparam int EDGE_TOP    = 3;
  localparam int EDGE_LEFT   = 2;
  localparam int EDGE_RIGHT  = 1;
  localparam int EDGE_BOTTOM = 0;

  localparam int DEFAULT_FRAC_BITS = 6;

endpackage

// File: rtl/speed_step.sv
// Combinational saturating step of a signed speed toward a target.
// PLAYER_ACCEL_EN selects ramping; otherwise the target is taken directly.
module speed_step #(
  parameter int W = 18
) (
  input  logic signed [W-1:0] speed,
  input  logic signed [W-1:0] target,
  input  logic signed [W-1:0] step,
  output logic signed [W-1:0] next_speed
);

`ifdef PLAYER_ACCEL_EN
  logic signed [W-1:0] sum_up;
  logic signed [W-1:0] sum_dn;

  assign sum_up = speed + step;
  assign sum_dn = speed - step;

  // The step never overshoots; a reversal simply walks through zero.
  always_comb begin
    next_speed = target;
    if (speed < target) begin
      next_speed = (sum_up > target) ? target : sum_up;
    end else if (speed > target) begin
      next_speed = (sum_dn < target) ? target : sum_dn;
    end
  end
`else
  logic unused_inputs;

  assign unused_inputs = ^{speed, step};
  assign next_speed    = target;
`endif

endmodule

// File: rtl/player_motion_fsm.sv
// Per-frame horizontal player motion: ramped speed, bound clamp, sticky
// collision capture and timed knockback. Optional ramping via PLAYER_ACCEL_EN.
//
// state | meaning
// IDLE  | speed is zero, keys evaluated each frame
// MOVE  | speed nonzero, keys evaluated each frame
// KNOCK | fixed knock speed for KNOCK_FRAMES frames, keys and hits ignored
module player_motion_fsm
  import player_pkg::*;
#(
  parameter int INITIAL_X    = 280,
  parameter int INITIAL_Y    = 185,
  parameter int X_MIN        = 10,
  parameter int X_MAX        = 556,
  parameter int FRAC_BITS    = DEFAULT_FRAC_BITS,
  parameter int MAX_SPEED    = 128,
  parameter int ACCEL        = 16,
  parameter int FRICTION     = 16,
  parameter int KNOCK_SPEED  = 192,
  parameter int KNOCK_FRAMES = 8
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               moveLeft,
  input  logic               moveRight,
  input  logic               collision,
  input  logic [3:0]         HitEdgeCode,
  output logic signed [10:0] topLeftX,
  output logic signed [10:0] topLeftY,
  output logic signed [10:0] speedX,
  output logic               knockActive
);

  localparam int W  = 11 + FRAC_BITS + 1;
  localparam int CW = $clog2(KNOCK_FRAMES) + 1;

  localparam logic signed [W-1:0] X_LO     = W'(X_MIN * (2 ** FRAC_BITS));
  localparam logic signed [W-1:0] X_HI     = W'(X_MAX * (2 ** FRAC_BITS));
  localparam logic signed [W-1:0] INIT_FP  = W'(INITIAL_X * (2 ** FRAC_BITS));
  localparam logic signed [W-1:0] MAX_FP   = W'(MAX_SPEED);
  localparam logic signed [W-1:0] ACCEL_FP = W'(ACCEL);
  localparam logic signed [W-1:0] FRIC_FP  = W'(FRICTION);
  localparam logic signed [W-1:0] KNOCK_FP = W'(KNOCK_SPEED);
  localparam logic [CW-1:0]       CNT_LOAD = CW'(KNOCK_FRAMES - 1);

  motion_state_t       state, state_n;
  logic signed [W-1:0] pos, pos_n;
  logic signed [W-1:0] speed, speed_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic                pending;
  logic [1:0]          edge_q;
  logic                knock_q;

  logic                pend_eff;
  logic [1:0]          edge_eff;
  logic signed [W-1:0] target;
  logic signed [W-1:0] step_sel;
  logic signed [W-1:0] stepped;
  logic signed [W-1:0] knock_dir;
  logic signed [W-1:0] mv;
  logic signed [W-1:0] sum;
  logic signed [W-1:0] pos_lim;
  logic                clamped;
  logic                unused_edges;

  assign unused_edges = ^{HitEdgeCode[EDGE_TOP], HitEdgeCode[EDGE_BOTTOM]};

  // A hit arriving on the tick cycle itself is honoured by that tick.
  assign pend_eff = pending | collision;
  assign edge_eff = collision ? {HitEdgeCode[EDGE_LEFT], HitEdgeCode[EDGE_RIGHT]} : edge_q;

  always_comb begin
    target = '0;
    if (!moveLeft && moveRight) begin
      target = -MAX_FP;
    end else if (moveLeft && !moveRight) begin
      target = MAX_FP;
    end
  end

  assign step_sel = (target != '0) ? ACCEL_FP : FRIC_FP;

  speed_step #(.W(W)) u_speed_step (
    .speed      (speed),
    .target     (target),
    .step       (step_sel),
    .next_speed (stepped)
  );

  always_comb begin
    knock_dir = -KNOCK_FP;
    if (edge_eff[1]) begin
      knock_dir = KNOCK_FP;
    end else if (edge_eff[0]) begin
      knock_dir = -KNOCK_FP;
    end else if (speed < 0) begin
      knock_dir = KNOCK_FP;
    end
  end

  always_comb begin
    mv = stepped;
    if (state == KNOCK) begin
      mv = speed;
    end else if (pend_eff) begin
      mv = knock_dir;
    end
  end

  assign sum = pos + mv;

  always_comb begin
    pos_lim = sum;
    clamped = 1'b0;
    if (sum > X_HI) begin
      pos_lim = X_HI;
      clamped = 1'b1;
    end else if (sum < X_LO) begin
      pos_lim = X_LO;
      clamped = 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    pos_n   = pos;
    speed_n = speed;
    cnt_n   = cnt;
    if (startOfFrame) begin
      pos_n = pos_lim;
      case (state)
        KNOCK: begin
          // The entry tick is the first knock frame, so leave after the
          // remaining KNOCK_FRAMES-1 frames.
          if (cnt <= CW'(1)) begin
            cnt_n   = '0;
            speed_n = '0;
            state_n = IDLE;
          end else begin
            cnt_n = cnt - CW'(1);
          end
        end
        default: begin
          if (pend_eff) begin
            speed_n = knock_dir;
            cnt_n   = CNT_LOAD;
            state_n = KNOCK;
          end else begin
            speed_n = clamped ? '0 : stepped;
            state_n = (speed_n == '0) ? IDLE : MOVE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state   <= IDLE;
      pos     <= INIT_FP;
      speed   <= '0;
      cnt     <= '0;
      knock_q <= 1'b0;
    end else begin
      state   <= state_n;
      pos     <= pos_n;
      speed   <= speed_n;
      cnt     <= cnt_n;
      knock_q <= (state_n == KNOCK);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pending <= 1'b0;
      edge_q  <= '0;
    end else if (startOfFrame) begin
      pending <= 1'b0;
    end else if (collision) begin
      pending <= 1'b1;
      edge_q  <= {HitEdgeCode[EDGE_LEFT], HitEdgeCode[EDGE_RIGHT]};
    end
  end

  assign topLeftX    = pos[FRAC_BITS+10:FRAC_BITS];
  assign topLeftY    = 11'(INITIAL_Y);
  assign speedX      = speed[10:0];
  assign knockActive = knock_q;

endmodule

// File: tb/tb_player_motion_fsm.sv
// Directed self-checking bench for player_motion_fsm; tracks the
// PLAYER_ACCEL_EN build option so expectations match either configuration.
module tb_player_motion_fsm;

  logic               clk;
  logic               resetN;
  logic               startOfFrame;
  logic               moveLeft;
  logic               moveRight;
  logic               collision;
  logic [3:0]         HitEdgeCode;
  logic signed [10:0] topLeftX;
  logic signed [10:0] topLeftY;
  logic signed [10:0] speedX;
  logic               knockActive;

  int checks   = 0;
  int failures = 0;

  player_motion_fsm dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .moveLeft     (moveLeft),
    .moveRight    (moveRight),
    .collision    (collision),
    .HitEdgeCode  (HitEdgeCode),
    .topLeftX     (topLeftX),
    .topLeftY     (topLeftY),
    .speedX       (speedX),
    .knockActive  (knockActive)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    resetN = 1'b0;
    moveLeft = 1'b1;
    moveRight = 1'b1;
    collision = 1'b0;
    startOfFrame = 1'b0;
    HitEdgeCode = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
  endtask

  task automatic tick();
    @(negedge clk);
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    @(negedge clk);
  endtask

  task automatic tick_hit(input logic [3:0] e);
    @(negedge clk);
    startOfFrame = 1'b1;
    collision = 1'b1;
    HitEdgeCode = e;
    @(negedge clk);
    startOfFrame = 1'b0;
    collision = 1'b0;
    HitEdgeCode = 4'b0000;
    @(negedge clk);
  endtask

  task automatic pulse_hit(input logic [3:0] e);
    @(negedge clk);
    collision = 1'b1;
    HitEdgeCode = e;
    @(negedge clk);
    collision = 1'b0;
    HitEdgeCode = 4'b0000;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (topLeftX !== 11'sd280) begin failures++; $display("FAIL reset_x got=%0d want=280", topLeftX); end
    checks++; if (topLeftY !== 11'sd185) begin failures++; $display("FAIL reset_y got=%0d want=185", topLeftY); end
    checks++; if (speedX !== 11'sd0) begin failures++; $display("FAIL reset_speed got=%0d want=0", speedX); end
    checks++; if (knockActive !== 1'b0) begin failures++; $display("FAIL reset_knock got=%b want=0", knockActive); end
  endtask

  // Knock from rest with no edge bits, then reset in the middle of KNOCK.
  task automatic test_reset_mid_knock();
    do_reset();
    tick_hit(4'b0000);
    checks++; if (speedX !== -11'sd192) begin failures++; $display("FAIL knock_rest_speed got=%0d want=-192", speedX); end
    checks++; if (topLeftX !== 11'sd277) begin failures++; $display("FAIL knock_rest_x got=%0d want=277", topLeftX); end
    checks++; if (knockActive !== 1'b1) begin failures++; $display("FAIL knock_rest_active got=%b want=1", knockActive); end
    tick();
    @(negedge clk);
    #2 resetN = 1'b0;
    #1;
    checks++; if (topLeftX !== 11'sd280 || speedX !== 11'sd0 || knockActive !== 1'b0)
      begin failures++; $display("FAIL async_reset got x=%0d v=%0d k=%b want 280/0/0", topLeftX, speedX, knockActive); end
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    tick();
    checks++; if (topLeftX !== 11'sd280 || speedX !== 11'sd0 || knockActive !== 1'b0 || topLeftY !== 11'sd185)
      begin failures++; $display("FAIL post_reset got x=%0d v=%0d k=%b y=%0d want 280/0/0/185", topLeftX, speedX, knockActive, topLeftY); end
    // Left-edge hit pushes right; hit captured between ticks.
    pulse_hit(4'b0100);
    tick();
    checks++; if (speedX !== 11'sd192 || topLeftX !== 11'sd283)
      begin failures++; $display("FAIL knock_left_edge got v=%0d x=%0d want 192/283", speedX, topLeftX); end
    for (int i = 0; i < 7; i++) tick();
    checks++; if (speedX !== 11'sd0 || topLeftX !== 11'sd304 || knockActive !== 1'b0)
      begin failures++; $display("FAIL knock_left_end got v=%0d x=%0d k=%b want 0/304/0", speedX, topLeftX, knockActive); end
  endtask

`ifdef PLAYER_ACCEL_EN
  task automatic test_accel();
    int exp_v;
    do_reset();
    moveRight = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      exp_v = (16 * k > 128) ? 128 : 16 * k;
      checks++; if (speedX !== 11'(exp_v)) begin failures++; $display("FAIL accel_speed tick=%0d got=%0d want=%0d", k, speedX, exp_v); end
    end
    checks++; if (topLeftX !== 11'sd293) begin failures++; $display("FAIL accel_x got=%0d want=293", topLeftX); end
  endtask

  task automatic test_friction();
    moveRight = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++; if (speedX !== 11'(128 - 16 * k)) begin failures++; $display("FAIL friction_speed tick=%0d got=%0d want=%0d", k, speedX, 128 - 16 * k); end
    end
    checks++; if (topLeftX !== 11'sd300) begin failures++; $display("FAIL friction_x got=%0d want=300", topLeftX); end
    moveRight = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    moveLeft = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++; if (speedX !== 11'(128 - 16 * k)) begin failures++; $display("FAIL both_keys_speed tick=%0d got=%0d want=%0d", k, speedX, 128 - 16 * k); end
    end
    moveLeft = 1'b1;
    moveRight = 1'b1;
  endtask
`else
  task automatic test_direct_speed();
    do_reset();
    moveLeft = 1'b0;
    tick();
    checks++; if (speedX !== -11'sd128 || topLeftX !== 11'sd278)
      begin failures++; $display("FAIL direct_left got v=%0d x=%0d want -128/278", speedX, topLeftX); end
    moveLeft = 1'b1;
    tick();
    checks++; if (speedX !== 11'sd0 || topLeftX !== 11'sd278)
      begin failures++; $display("FAIL direct_release got v=%0d x=%0d want 0/278", speedX, topLeftX); end
    moveRight = 1'b0;
    tick();
    checks++; if (speedX !== 11'sd128 || topLeftX !== 11'sd280)
      begin failures++; $display("FAIL direct_right got v=%0d x=%0d want 128/280", speedX, topLeftX); end
    moveLeft = 1'b0;
    tick();
    checks++; if (speedX !== 11'sd0 || topLeftX !== 11'sd280)
      begin failures++; $display("FAIL direct_both got v=%0d x=%0d want 0/280", speedX, topLeftX); end
    moveLeft = 1'b1;
    moveRight = 1'b1;
  endtask

  task automatic test_right_bound();
    do_reset();
    moveRight = 1'b0;
    for (int k = 0; k < 135; k++) tick();
    checks++; if (topLeftX !== 11'sd550) begin failures++; $display("FAIL rbound_start got=%0d want=550", topLeftX); end
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++; if (topLeftX !== 11'(550 + 2 * k) || speedX !== 11'sd128)
        begin failures++; $display("FAIL rbound_approach tick=%0d got x=%0d v=%0d want %0d/128", k, topLeftX, speedX, 550 + 2 * k); end
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++; if (topLeftX !== 11'sd556 || speedX !== 11'sd0)
        begin failures++; $display("FAIL rbound_clamp tick=%0d got x=%0d v=%0d want 556/0", k, topLeftX, speedX); end
    end
    moveRight = 1'b1;
  endtask

  task automatic test_left_bound();
    do_reset();
    moveLeft = 1'b0;
    for (int k = 0; k < 135; k++) tick();
    checks++; if (topLeftX !== 11'sd10 || speedX !== -11'sd128)
      begin failures++; $display("FAIL lbound_edge got x=%0d v=%0d want 10/-128", topLeftX, speedX); end
    tick();
    checks++; if (topLeftX !== 11'sd10 || speedX !== 11'sd0)
      begin failures++; $display("FAIL lbound_clamp got x=%0d v=%0d want 10/0", topLeftX, speedX); end
    moveLeft = 1'b1;
  endtask

  task automatic test_knockback();
    do_reset();
    moveRight = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    checks++; if (topLeftX !== 11'sd300 || speedX !== 11'sd128)
      begin failures++; $display("FAIL knock_setup got x=%0d v=%0d want 300/128", topLeftX, speedX); end
    pulse_hit(4'b0010);
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 3) pulse_hit(4'b0100);
      if (k < 8) begin
        checks++; if (speedX !== -11'sd192 || knockActive !== 1'b1 || topLeftX !== 11'(300 - 3 * k))
          begin failures++; $display("FAIL knock_frame tick=%0d got v=%0d k=%b x=%0d want -192/1/%0d", k, speedX, knockActive, topLeftX, 300 - 3 * k); end
      end
    end
    checks++; if (topLeftX !== 11'sd276 || speedX !== 11'sd0 || knockActive !== 1'b0)
      begin failures++; $display("FAIL knock_end got x=%0d v=%0d k=%b want 276/0/0", topLeftX, speedX, knockActive); end
    tick();
    checks++; if (topLeftX !== 11'sd278 || speedX !== 11'sd128 || knockActive !== 1'b0)
      begin failures++; $display("FAIL knock_discard got x=%0d v=%0d k=%b want 278/128/0", topLeftX, speedX, knockActive); end
    moveRight = 1'b1;
  endtask

  // Back-to-back: moving left, a hit with no edge bits reverses to the right.
  task automatic test_back_to_back();
    do_reset();
    moveLeft = 1'b0;
    tick();
    tick_hit(4'b0000);
    checks++; if (speedX !== 11'sd192 || topLeftX !== 11'sd281 || knockActive !== 1'b1)
      begin failures++; $display("FAIL knock_reverse got v=%0d x=%0d k=%b want 192/281/1", speedX, topLeftX, knockActive); end
    moveLeft = 1'b1;
  endtask
`endif

  initial begin
    resetN = 1'b0;
    startOfFrame = 1'b0;
    moveLeft = 1'b1;
    moveRight = 1'b1;
    collision = 1'b0;
    HitEdgeCode = 4'b0000;
    test_reset();
    test_reset_mid_knock();
`ifdef PLAYER_ACCEL_EN
    test_accel();
    test_friction();
`else
    test_direct_speed();
    test_right_bound();
    test_left_bound();
    test_knockback();
    test_back_to_back();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
